// File: rtl/wind_pkg.sv
// Shared types and defaults for the wind statistics block.
// WINDSTAT_LULL_EN adds the window minimum (lull) to the result struct.
package wind_pkg;

    localparam int SPD_W_DEF = 16;
    localparam int DIR_W_DEF = 16;
    localparam int FRAC_BITS = 10;

    typedef enum logic {
        ACC  = 1'b0,
        DONE = 1'b1
    } wind_state_t;

    typedef struct packed {
        logic [SPD_W_DEF-1:0] mean;
        logic [SPD_W_DEF-1:0] gust;
        logic [DIR_W_DEF-1:0] gust_dir;
`ifdef WINDSTAT_LULL_EN
        logic [SPD_W_DEF-1:0] lull;
`endif
    } wind_result_t;

endpackage

// File: rtl/wind_peak_track.sv
// Running maximum with its direction tag; with WINDSTAT_LULL_EN also the running minimum.
// restart makes the current sample the new reference regardless of history.
module wind_peak_track #(
    parameter int SPD_W = 16,
    parameter int DIR_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             update,
    input  logic             restart,
    input  logic [SPD_W-1:0] value,
    input  logic [DIR_W-1:0] tag,
    output logic [SPD_W-1:0] peak,
    output logic [DIR_W-1:0] peak_tag
`ifdef WINDSTAT_LULL_EN
    ,
    output logic [SPD_W-1:0] lull
`endif
);

    // Strictly greater: ties keep the earliest sample's tag.
    always_ff @(posedge clock) begin
        if (reset) begin
            peak     <= '0;
            peak_tag <= '0;
        end else if (update && (restart || value > peak)) begin
            peak     <= value;
            peak_tag <= tag;
        end
    end

`ifdef WINDSTAT_LULL_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            lull <= '0;
        end else if (update && (restart || value < lull)) begin
            lull <= value;
        end
    end
`endif

endmodule

// File: rtl/wind_stats.sv
// Per-window mean speed, peak gust and gust direction over 2^LOG2N samples.
// WINDSTAT_LULL_EN adds the window minimum on lull_speed.
module wind_stats
    import wind_pkg::*;
#(
    parameter int LOG2N = 4,
    parameter int SPD_W = SPD_W_DEF,
    parameter int DIR_W = DIR_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [SPD_W-1:0] speed,
    input  logic [DIR_W-1:0] direction,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SPD_W-1:0] mean_speed,
    output logic [SPD_W-1:0] gust_speed,
    output logic [DIR_W-1:0] gust_dir,
`ifdef WINDSTAT_LULL_EN
    output logic [SPD_W-1:0] lull_speed,
`endif
    output logic             overrun
);

    localparam logic [LOG2N-1:0] CNT_LAST = '1;

    wind_state_t             state, next_state;
    logic [LOG2N-1:0]        count;
    logic [SPD_W+LOG2N-1:0]  acc;
    logic [SPD_W-1:0]        peak;
    logic [DIR_W-1:0]        peak_dir;
    wind_result_t            result, res_q;
    logic                    first;
    logic                    load;

    // count wraps to zero on the closing sample, so a zero count always marks
    // the first sample of the next window, including one arriving in DONE.
    assign first = (count == '0);

    wind_peak_track #(.SPD_W(SPD_W), .DIR_W(DIR_W)) u_peak (
        .clock    (clock),
        .reset    (reset),
        .update   (in_valid),
        .restart  (first),
        .value    (speed),
        .tag      (direction),
        .peak     (peak),
        .peak_tag (peak_dir)
`ifdef WINDSTAT_LULL_EN
        ,
        .lull     (result.lull)
`endif
    );

    always_ff @(posedge clock) begin
        if (reset) state <= ACC;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            ACC:  if (in_valid && count == CNT_LAST) next_state = DONE;
            DONE: next_state = ACC;
            default: next_state = ACC;
        endcase
    end

    always_comb begin
        result.mean     = acc[LOG2N +: SPD_W];
        result.gust     = peak;
        result.gust_dir = peak_dir;
    end

    // Handshake: the buffer is full while out_valid is high; it empties on a
    // cycle where out_valid & out_ready, and a DONE in that same cycle refills it.
    assign load = (state == DONE) && (!out_valid || out_ready);

    always_ff @(posedge clock) begin
        if (reset) begin
            count     <= '0;
            acc       <= '0;
            res_q     <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (in_valid) begin
                count <= count + 1'b1;
                acc   <= first ? {{LOG2N{1'b0}}, speed}
                               : acc + {{LOG2N{1'b0}}, speed};
            end
            if (load) begin
                res_q     <= result;
                out_valid <= 1'b1;
            end else if (state == DONE) begin
                overrun <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign mean_speed = res_q.mean;
    assign gust_speed = res_q.gust;
    assign gust_dir   = res_q.gust_dir;
`ifdef WINDSTAT_LULL_EN
    assign lull_speed = res_q.lull;
`endif

endmodule
